// File: rtl/serial_word_assembler_pkg.sv
// Shared definitions for the serial word assembler.
//   state_t   : FSM states (COLLECT gathers bits, HOLD parks a finished word)
//   cnt_width : width of the bit counter, wide enough to hold 0..w inclusive
package serial_word_assembler_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_word_assembler_if.sv
// Handshake bundle for the serial word assembler.
//   din/din_valid/din_ready      : serial input bit stream
//   lsb_first                    : bit order of the word being started
//   dout/dout_valid/dout_ready   : parallel word output
//   bit_count                    : bits collected into the current word
// Modports: slave = assembler side, master = producer/consumer side.
interface serial_word_assembler_if
    import serial_word_assembler_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                                din;
    logic                                din_valid;
    logic                                din_ready;
    logic                                lsb_first;
    logic [DATA_WIDTH-1:0]               dout;
    logic                                dout_valid;
    logic                                dout_ready;
    logic [cnt_width(DATA_WIDTH)-1:0]    bit_count;

    modport slave (
        input  din, din_valid, lsb_first, dout_ready,
        output din_ready, dout, dout_valid, bit_count
    );

    modport master (
        output din, din_valid, lsb_first, dout_ready,
        input  din_ready, dout, dout_valid, bit_count
    );

endinterface

// File: rtl/serial_shift_collector.sv
// Shift register, bit counter and bit-order select for the assembler.
//   i_accept    : a bit is taken this cycle
//   i_din       : the serial bit
//   i_lsb_first : order request, only sampled with the first bit of a word
//   i_clear     : restart the counter (word left for the output register)
//   o_word      : registered shift contents (the full word while held)
//   o_next_word : shift contents including the bit accepted this cycle
//   o_count     : bits collected into the current word
//   o_last      : the bit accepted this cycle completes the word
module serial_shift_collector
    import serial_word_assembler_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    localparam int CW         = cnt_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_accept,
    input  logic                  i_din,
    input  logic                  i_lsb_first,
    input  logic                  i_clear,
    output logic [DATA_WIDTH-1:0] o_word,
    output logic [DATA_WIDTH-1:0] o_next_word,
    output logic [CW-1:0]         o_count,
    output logic                  o_last
);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_count;
    logic                  r_order;
    logic                  w_first;
    logic                  w_order;
    logic [DATA_WIDTH-1:0] w_shifted;

    // The first bit of a word uses the live order input; later bits use the
    // value latched with that first bit so mid-word changes are ignored.
    assign w_first = (r_count == '0);
    assign w_order = w_first ? i_lsb_first : r_order;

    // MSB-first shifts left so the first bit ends at the top; LSB-first
    // shifts right so the first bit ends at bit 0.
    assign w_shifted = w_order ? {i_din, r_shift[DATA_WIDTH-1:1]}
                               : {r_shift[DATA_WIDTH-2:0], i_din};

    assign o_word      = r_shift;
    assign o_next_word = w_shifted;
    assign o_count     = r_count;
    assign o_last      = i_accept && (r_count == CW'(DATA_WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_count <= '0;
            r_order <= 1'b0;
        end else begin
            if (i_accept) begin
                r_shift <= w_shifted;
                if (w_first) begin
                    r_order <= i_lsb_first;
                end
            end
            if (i_clear) begin
                r_count <= '0;
            end else if (i_accept) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : slave side of serial_word_assembler_if (serial input,
//                parallel output handshake, bit order, bit count)
// A finished word goes straight into the output register when it is empty
// or draining; otherwise it waits in the collector (HOLD) until it can.
module serial_word_assembler
    import serial_word_assembler_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_word_assembler_if.slave  bus
);

    localparam int CW = cnt_width(DATA_WIDTH);

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_valid;
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] w_next_word;
    logic [DATA_WIDTH-1:0] w_load_word;
    logic [CW-1:0]         w_count;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_drain;
    logic                  w_out_free;
    logic                  w_load;
    logic                  w_clear;

    assign w_accept   = bus.din_valid && (r_state == COLLECT);
    assign w_drain    = r_dout_valid && bus.dout_ready;
    assign w_out_free = !r_dout_valid || bus.dout_ready;

    serial_shift_collector #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_collector (
        .clk         (clk),
        .reset       (reset),
        .i_accept    (w_accept),
        .i_din       (bus.din),
        .i_lsb_first (bus.lsb_first),
        .i_clear     (w_clear),
        .o_word      (w_word),
        .o_next_word (w_next_word),
        .o_count     (w_count),
        .o_last      (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        w_load_word  = w_next_word;
        case (r_state)
            COLLECT: begin
                if (w_last) begin
                    if (w_out_free) begin
                        w_load  = 1'b1;
                        w_clear = 1'b1;
                    end else begin
                        w_next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (w_drain) begin
                    w_load       = 1'b1;
                    w_clear      = 1'b1;
                    w_load_word  = w_word;
                    w_next_state = COLLECT;
                end
            end
            default: begin
                w_next_state = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_load) begin
            r_dout       <= w_load_word;
            r_dout_valid <= 1'b1;
        end else if (w_drain) begin
            r_dout_valid <= 1'b0;
        end
    end

    assign bus.din_ready  = (r_state == COLLECT);
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.bit_count  = w_count;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed bench for serial_word_assembler with DATA_WIDTH=8.
module tb_serial_word_assembler;
    import serial_word_assembler_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_word_assembler_if #(.DATA_WIDTH(W)) bus();

    serial_word_assembler #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // seq[7] is sent first; lsbm[7-i] is the lsb_first value driven with bit i.
    typedef struct {
        logic [7:0] seq;
        logic [7:0] lsbm;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic send_word(input logic [7:0] seq, input logic [7:0] lsbm);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.din       = seq[7-i];
            bus.lsb_first = lsbm[7-i];
            bus.din_valid = 1'b1;
        end
        @(negedge clk);
        bus.din_valid = 1'b0;
        bus.din       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] words[4];
        logic [7:0] w2;

        vecs[0] = '{seq: 8'hB2, lsbm: 8'h00, exp: 8'hB2};
        vecs[1] = '{seq: 8'hB2, lsbm: 8'hFF, exp: 8'h4D};
        vecs[2] = '{seq: 8'hF0, lsbm: 8'h00, exp: 8'hF0};
        vecs[3] = '{seq: 8'hF0, lsbm: 8'hFF, exp: 8'h0F};
        vecs[4] = '{seq: 8'h80, lsbm: 8'hFF, exp: 8'h01};
        vecs[5] = '{seq: 8'hD2, lsbm: 8'h1F, exp: 8'hD2}; // order flips mid-word
        vecs[6] = '{seq: 8'hD2, lsbm: 8'hFF, exp: 8'h4B}; // new order applies now
        vecs[7] = '{seq: 8'h01, lsbm: 8'h00, exp: 8'h01};

        reset          = 1'b1;
        bus.din        = 1'b0;
        bus.din_valid  = 1'b0;
        bus.lsb_first  = 1'b0;
        bus.dout_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_din_ready", bus.din_ready, 1);
        check("rst_dout_valid", bus.dout_valid, 0);
        check("rst_bit_count", bus.bit_count, 0);
        check("rst_dout", bus.dout, 0);
        reset = 1'b0;

        // dout_ready with nothing valid does nothing
        @(negedge clk);
        @(negedge clk);
        check("idle_dout_valid", bus.dout_valid, 0);
        check("idle_bit_count", bus.bit_count, 0);

        // Table of single words with downstream always ready
        for (int v = 0; v < 8; v++) begin
            send_word(vecs[v].seq, vecs[v].lsbm);
            check($sformatf("vec%0d_valid", v), bus.dout_valid, 1);
            check($sformatf("vec%0d_dout", v), bus.dout, vecs[v].exp);
            check($sformatf("vec%0d_count", v), bus.bit_count, 0);
            @(negedge clk);
            check($sformatf("vec%0d_drained", v), bus.dout_valid, 0);
        end

        // Backpressure: two words while downstream stalls
        bus.dout_ready = 1'b0;
        send_word(8'hFF, 8'h00);
        check("bp_first_valid", bus.dout_valid, 1);
        check("bp_first_dout", bus.dout, 8'hFF);
        check("bp_first_ready", bus.din_ready, 1);
        send_word(8'h00, 8'h00);
        check("bp_hold_din_ready", bus.din_ready, 0);
        check("bp_hold_count", bus.bit_count, 8);
        check("bp_hold_dout", bus.dout, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        check("bp_stable_dout", bus.dout, 8'hFF);
        check("bp_stable_valid", bus.dout_valid, 1);
        bus.dout_ready = 1'b1;
        @(negedge clk);
        check("bp_second_dout", bus.dout, 8'h00);
        check("bp_second_valid", bus.dout_valid, 1);
        check("bp_release_ready", bus.din_ready, 1);
        check("bp_release_count", bus.bit_count, 0);
        @(negedge clk);
        check("bp_drained", bus.dout_valid, 0);

        // Word completes on the same edge the previous word drains
        bus.dout_ready = 1'b0;
        send_word(8'h12, 8'h00);
        check("dr_first_dout", bus.dout, 8'h12);
        w2 = 8'h34;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.din        = w2[7-i];
            bus.lsb_first  = 1'b0;
            bus.din_valid  = 1'b1;
            bus.dout_ready = (i == 7);
        end
        @(negedge clk);
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        check("dr_second_dout", bus.dout, 8'h34);
        check("dr_second_valid", bus.dout_valid, 1);
        check("dr_din_ready", bus.din_ready, 1);
        check("dr_count", bus.bit_count, 0);

        // Reset in the middle of a word with a word still valid
        w2 = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.din       = w2[7-i];
            bus.din_valid = 1'b1;
        end
        @(negedge clk);
        bus.din_valid = 1'b0;
        check("mid_count", bus.bit_count, 5);
        reset = 1'b1;
        #1;
        check("async_rst_count", bus.bit_count, 0);
        check("async_rst_valid", bus.dout_valid, 0);
        check("async_rst_dout", bus.dout, 0);
        check("async_rst_ready", bus.din_ready, 1);
        #2;
        reset = 1'b0;
        bus.dout_ready = 1'b1;
        send_word(8'hA5, 8'h00);
        check("post_rst_valid", bus.dout_valid, 1);
        check("post_rst_dout", bus.dout, 8'hA5);
        @(negedge clk);
        check("post_rst_drained", bus.dout_valid, 0);

        // Continuous stream of four words
        words[0] = 8'h12;
        words[1] = 8'h34;
        words[2] = 8'h56;
        words[3] = 8'h78;
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            check($sformatf("stream_ready%0d", j), bus.din_ready, 1);
            check($sformatf("stream_valid%0d", j), bus.dout_valid, (j != 0) && (j % 8 == 0));
            if ((j != 0) && (j % 8 == 0)) begin
                check($sformatf("stream_dout%0d", j), bus.dout, words[j/8-1]);
            end
            w2            = words[j/8];
            bus.din       = w2[7 - (j % 8)];
            bus.lsb_first = 1'b0;
            bus.din_valid = 1'b1;
        end
        @(negedge clk);
        bus.din_valid = 1'b0;
        check("stream_last_valid", bus.dout_valid, 1);
        check("stream_last_dout", bus.dout, 8'h78);
        @(negedge clk);
        check("stream_end_valid", bus.dout_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_word_assembler.md
SERIAL_WORD_ASSEMBLER -- requirements
Module: serial_word_assembler

Interface
REQ-001 Parameter DATA_WIDTH, default 32; word width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 din  input  1  serial data bit.
REQ-005 din_valid  input  1  din holds a valid bit this cycle.
REQ-006 din_ready  output  1  block accepts a bit this cycle.
REQ-007 lsb_first  input  1  bit order of the word; 0 = MSB-first, 1 = LSB-first.
REQ-008 dout  output  DATA_WIDTH  assembled parallel word.
REQ-009 dout_valid  output  1  dout holds a complete word.
REQ-010 dout_ready  input  1  downstream consumes dout this cycle.
REQ-011 bit_count  output  clog2(DATA_WIDTH+1)  number of bits collected into the current word.

Function
REQ-012 A bit SHALL be accepted only in a cycle where din_valid=1 and din_ready=1.
REQ-013 lsb_first SHALL be sampled with the first bit of each word and held for that whole word; changes mid-word SHALL be ignored.
REQ-014 MSB-first: the k-th accepted bit (k=0..W-1) SHALL land in dout[W-1-k].
REQ-015 LSB-first: the k-th accepted bit SHALL land in dout[k].
REQ-016 The FSM SHALL have two states, COLLECT and HOLD.
REQ-017 COLLECT: din_ready=1; bit_count SHALL increment on each accepted bit.
REQ-018 Word complete (W-th bit accepted) and output register empty or draining that cycle: the word SHALL move to dout on the same edge, dout_valid=1 the next cycle, bit_count -> 0, and the FSM stays in COLLECT.
REQ-019 Word complete and output register occupied and not draining: the FSM SHALL enter HOLD with bit_count=W.
REQ-020 HOLD: din_ready=0.
REQ-021 HOLD: on the first cycle with dout_valid=1 and dout_ready=1, the held word SHALL move to dout, dout_valid SHALL remain 1, bit_count -> 0, and the FSM SHALL return to COLLECT.
REQ-022 Output handshake: dout_valid SHALL clear after a cycle with dout_valid=1 and dout_ready=1 when no new word transfers on that edge.
REQ-023 While dout_valid=1 and dout_ready=0, dout SHALL be stable.
REQ-024 Sustained throughput SHALL be one bit per cycle with no bubble between words when dout_ready=1.
REQ-025 Latency: the last bit is accepted at edge N; dout_valid=1 from edge N (visible in cycle N+1).
REQ-026 dout_ready while dout_valid=0 SHALL have no effect.

Reset
REQ-027 Reset assertion SHALL immediately force FSM=COLLECT, bit_count=0, dout=0, dout_valid=0, din_ready=1, and discard any partial word.
REQ-028 Reset asserted mid-word or in HOLD SHALL lose the pending data.
REQ-029 The first bit after reset deassertion SHALL begin a new word.

Structure
REQ-030 The FSM state enum (COLLECT, HOLD) SHALL live in the shared package.
REQ-031 The count-width helper constant SHALL also live in the shared package.
REQ-032 The block SHALL contain one sub-module, serial_shift_collector: shift register, bit counter and order select; FSM and output register in the top module.

Verification (DATA_WIDTH=8)
REQ-033 MSB-first, bits 1,0,1,1,0,0,1,0 back-to-back with dout_ready=1 -> dout=8'hB2 and dout_valid=1 one cycle after the 8th bit.
REQ-034 Same bits with lsb_first=1 -> dout=8'h4D.
REQ-035 dout_ready=0 while two words of 8'hFF then 8'h00 are sent -> HOLD entered and din_ready=0 after 16 bits. Then dout_ready=1 for 2 cycles -> 8'hFF then 8'h00, in order, no loss.
REQ-036 Toggle lsb_first after bit 3 of a word -> order unchanged for that word; new value applies from the next word.
REQ-037 Reset pulse after 5 bits -> bit_count=0 and dout_valid=0 immediately. Next 8 bits 8'hA5 -> dout=8'hA5.
REQ-038 Continuous stream of 4 words with dout_ready=1 -> dout_valid pulses every 8 cycles and din_ready stays 1 throughout.
